risc_v_processor: RTL and testbench

//  Single-cycle RV32I-subset core: PC, instruction ROM, 32x32 register file, imm generator,

---
 rtl/risc_v_processor.sv | 166 ++++++++++++++++
 tb/tb_risc_v_processor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_processor.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback all
// complete in one clock. The only ports are clock and reset.

module risc_v_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] regFile [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (we_i && (rd != 5'd0)) begin
      regFile[rd] <= wd_i;
    end
  end

  assign rd1_o = (rs1_i == 5'd0) ? '0 : regFile[rs1_i];
  assign rd2_o = (rs2_i == 5'd0) ? '0 : regFile[rs2_i];
endmodule

module risc_v_processor #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_INIT  = "imem.hex",
  parameter string       DMEM_INIT  = "dmem.hex"
) (
  input logic clk,
  input logic rst
);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] dmem [0:DMEM_DEPTH-1];

  logic [31:0] pc_out, pc_d;
  logic [31:0] I, read1, read2, imm, A, B, Result, data_memory_read, wd;
  logic [4:0]  rd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [IAW-1:0] i_idx;
  logic [DAW-1:0] d_idx;
  logic        reg_write, mem_write, mem_to_reg, branch, use_rs2, zero;
  alu_op_e     alu_op;

  // Memory images start at their fill values.
  initial begin
    for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP;
    for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_out <= '0;
    else      pc_out <= pc_d;
  end

  assign i_idx = pc_out[IAW+1:2];
  assign I     = (pc_out[31:2] < 30'(IMEM_DEPTH)) ? imem[i_idx] : NOP;

  assign opcode = I[6:0];
  assign rd     = I[11:7];
  assign funct3 = I[14:12];
  assign imm_i  = {{20{I[31]}}, I[31:20]};
  assign imm_s  = {{20{I[31]}}, I[31:25], I[11:7]};
  assign imm_b  = {{19{I[31]}}, I[31], I[7], I[30:25], I[11:8], 1'b0};

  // Encodings outside the supported subset fall through with every write disabled.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    use_rs2    = 1'b0;
    alu_op     = ALU_ADD;
    imm        = '0;
    case (opcode)
      OP_R: begin
        use_rs2   = 1'b1;
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_op = I[30] ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: reg_write = 1'b0;
        endcase
      end
      OP_IMM: if (funct3 == 3'b000) begin
        reg_write = 1'b1;
        imm       = imm_i;
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        imm        = imm_i;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        mem_write = 1'b1;
        imm       = imm_s;
      end
      OP_BRANCH: if (funct3 == 3'b000) begin
        branch  = 1'b1;
        use_rs2 = 1'b1;
        alu_op  = ALU_SUB;
        imm     = imm_b;
      end
      default: ;
    endcase
  end

  risc_v_regfile reg_file (
    .clk   (clk),
    .rst   (rst),
    .we_i  (reg_write),
    .rs1_i (I[19:15]),
    .rs2_i (I[24:20]),
    .rd    (rd),
    .wd_i  (wd),
    .rd1_o (read1),
    .rd2_o (read2)
  );

  assign A = read1;
  assign B = use_rs2 ? read2 : imm;

  always_comb begin
    Result = '0;
    case (alu_op)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {31'd0, $signed(A) < $signed(B)};
      default: Result = '0;
    endcase
  end

  assign zero = (Result == 32'd0);

  assign d_idx            = DAW'(Result[31:2] % 30'(DMEM_DEPTH));
  assign data_memory_read = dmem[d_idx];

  always_ff @(posedge clk) begin
    if (mem_write) dmem[d_idx] <= read2;
  end

  assign wd   = mem_to_reg ? data_memory_read : Result;
  assign pc_d = (branch && zero) ? pc_out + imm : pc_out + 32'd4;
endmodule

// File: tb/tb_risc_v_processor.sv
// Bench for risc_v_processor: directed program with known results, then random programs
// compared each cycle against an instruction-level reference model.

module tb_risc_v_processor;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    logic [31:0] prog  [32];
    logic [31:0] m_x   [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    risc_v_processor #(
        .IMEM_DEPTH (32),
        .DMEM_DEPTH (64),
        .IMEM_INIT  (""),
        .DMEM_INIT  ("")
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] v;
        v = 12'(imm);
        return {v, 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 32; i++) dut.imem[i] = prog[i];
    endtask

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules.
    task automatic model_step();
        logic [31:0] ins, a, b, ii, is, ib, nxt;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          idx, w;
        idx = int'(m_pc >> 2);
        ins = (idx < 32) ? prog[idx] : NOP;
        rd  = ins[11:7];
        f3  = ins[14:12];
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        nxt = m_pc + 4;
        case (ins[6:0])
            7'b0110011: begin
                if (f3 == 3'b000 && !ins[30]) begin if (rd != 0) m_x[rd] = a + b; end
                else if (f3 == 3'b000)        begin if (rd != 0) m_x[rd] = a - b; end
                else if (f3 == 3'b111)        begin if (rd != 0) m_x[rd] = a & b; end
                else if (f3 == 3'b110)        begin if (rd != 0) m_x[rd] = a | b; end
                else if (f3 == 3'b010)        begin if (rd != 0) m_x[rd] = ($signed(a) < $signed(b)) ? 1 : 0; end
            end
            7'b0010011: if (f3 == 3'b000 && rd != 0) m_x[rd] = a + ii;
            7'b0000011: if (f3 == 3'b010) begin
                w = int'(((a + ii) >> 2) % 64);
                if (rd != 0) m_x[rd] = m_mem[w];
            end
            7'b0100011: if (f3 == 3'b010) begin
                w = int'(((a + is) >> 2) % 64);
                m_mem[w] = b;
            end
            7'b1100011: if (f3 == 3'b000 && a == b) nxt = m_pc + ib;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("pc", dut.pc_out, m_pc);
        for (int r = 0; r < 32; r++)
            check($sformatf("x%0d", r), dut.reg_file.regFile[r], m_x[r]);
    endtask

    function automatic logic [31:0] rand_insn();
        int k, rd, rs1, rs2;
        k   = int'($urandom_range(0, 9));
        rd  = int'($urandom_range(0, 7));
        rs1 = int'($urandom_range(0, 7));
        rs2 = int'($urandom_range(0, 7));
        case (k)
            0: return enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd);
            1: return enc_r(7'h00, rs2, rs1, 3'b111, rd);
            2: return enc_r(7'h00, rs2, rs1, 3'b110, rd);
            3: return enc_r(7'h00, rs2, rs1, 3'b010, rd);
            4, 5: return enc_i(int'($urandom_range(0, 4095)), rs1, 3'b000, rd, 7'b0010011);
            6: return enc_i(int'($urandom_range(0, 4095)), rs1, 3'b010, rd, 7'b0000011);
            7: return enc_s(int'($urandom_range(0, 4095)), rs2, rs1);
            8: return enc_b((int'($urandom_range(0, 8)) - 4) * 4,
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        for (int i = 0; i < 32; i++) prog[i] = NOP;
        prog[0]  = enc_i(7, 0, 3'b000, 1, 7'b0010011);
        prog[1]  = enc_i(-3, 0, 3'b000, 2, 7'b0010011);
        prog[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);
        prog[3]  = enc_r(7'h20, 2, 1, 3'b000, 4);
        prog[4]  = enc_r(7'h00, 1, 2, 3'b010, 5);
        prog[5]  = enc_i(12, 0, 3'b000, 1, 7'b0010011);
        prog[6]  = enc_i(10, 0, 3'b000, 2, 7'b0010011);
        prog[7]  = enc_r(7'h00, 2, 1, 3'b111, 6);
        prog[8]  = enc_r(7'h00, 2, 1, 3'b110, 7);
        prog[9]  = enc_i(5, 0, 3'b000, 0, 7'b0010011);
        prog[10] = enc_i(25, 0, 3'b000, 9, 7'b0010011);
        prog[11] = enc_s(8, 9, 0);
        prog[12] = enc_i(8, 0, 3'b010, 8, 7'b0000011);
        prog[13] = enc_s(12, 8, 0);
        prog[14] = enc_b(8, 1, 1);
        prog[15] = enc_i(1, 0, 3'b000, 10, 7'b0010011);
        prog[16] = enc_b(8, 2, 1);
        prog[17] = enc_b(-68, 0, 0);
        #1;
        load_prog();
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", dut.pc_out, 32'h0);
        check("reset_x5", dut.reg_file.regFile[5], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_pc", dut.pc_out, 32'h0);
        step();
        check("pc_seq4", dut.pc_out, 32'h4);
        step();
        check("pc_seq8", dut.pc_out, 32'h8);
        repeat (3) step();
        check("add_x3", dut.reg_file.regFile[3], 32'd4);
        check("sub_x4", dut.reg_file.regFile[4], 32'd10);
        check("slt_x5", dut.reg_file.regFile[5], 32'd1);
        repeat (4) step();
        check("and_x6", dut.reg_file.regFile[6], 32'd8);
        check("or_x7", dut.reg_file.regFile[7], 32'd14);
        step();
        check("x0_read", dut.read1, 32'h0);
        repeat (2) step();
        check("lw_dmr", dut.data_memory_read, 32'd25);
        step();
        check("lw_x8", dut.reg_file.regFile[8], 32'd25);
        step();
        check("sw_word3", dut.dmem[3], 32'd25);
        step();
        check("beq_taken", dut.pc_out, 32'h40);
        step();
        check("beq_not_taken", dut.pc_out, 32'h44);
        step();
        check("beq_back", dut.pc_out, 32'h0);
        for (int n = 0; n < 20 && m_pc != 32'h20; n++) step();
        check("reach_pc20", dut.pc_out, 32'h20);

        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_pc", dut.pc_out, 32'h0);
        for (int r = 0; r < 32; r++)
            check($sformatf("async_x%0d", r), dut.reg_file.regFile[r], 32'h0);
        check("async_word3", dut.dmem[3], 32'd25);

        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 32; i++) prog[i] = rand_insn();
            load_prog();
            model_reset();
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            for (int s = 0; s < 64; s++) step();
            for (int w = 0; w < 64; w++)
                check($sformatf("r%0d_mem%0d", round, w), dut.dmem[w], m_mem[w]);
            rst = 1'b0;
            #1;
            model_reset();
            check("rand_reset_pc", dut.pc_out, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
